// File: rtl/cpu_init_pkg.sv
// Shared constants, FSM states and helpers for the CPU table-init loader.
// CHECKSUM_EN adds the CHECK state used for trailing-checksum records.
package cpu_init_pkg;

  localparam logic [1:0] REC_BTB = 2'b00;
  localparam logic [1:0] REC_BHT = 2'b01;
  localparam logic [1:0] REC_REG = 2'b10;
  localparam logic [1:0] REC_CMD = 2'b11;

  localparam logic [5:0] CMD_START = 6'h00;
  localparam logic [5:0] CMD_STOP  = 6'h01;

  localparam logic [2:0] LEN_BTB = 3'd5;
  localparam logic [2:0] LEN_BHT = 3'd1;
  localparam logic [2:0] LEN_REG = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
`ifdef CHECKSUM_EN
    ST_CHECK,
`endif
    ST_COMMIT
  } state_t;

  function automatic logic [2:0] payload_len(input logic [1:0] rec);
    case (rec)
      REC_BTB: return LEN_BTB;
      REC_BHT: return LEN_BHT;
      default: return LEN_REG;
    endcase
  endfunction

endpackage

// File: rtl/cpu_init_loader_if.sv
// Byte-stream input plus CPU init bus. The master modport is the loader side,
// the slave modport is the byte source / CPU side.
interface cpu_init_loader_if #(
  parameter int BTB_W  = 40,
  parameter int BTB_AW = 8,
  parameter int BHT_W  = 2,
  parameter int BHT_AW = 8,
  parameter int REG_W  = 32,
  parameter int REG_AW = 5
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic [BTB_AW-1:0] btb_addr;
  logic [BTB_W-1:0]  btb_init;
  logic              btb_we;
  logic [BHT_AW-1:0] bht_addr;
  logic [BHT_W-1:0]  bht_init;
  logic              bht_we;
  logic [REG_AW-1:0] reg_addr;
  logic [REG_W-1:0]  reg_init;
  logic              reg_we;
  logic              rst_switch;
  logic              start_switch;
  logic              busy;
  logic              err;

  modport master (
    input  s_valid, s_data,
    output s_ready,
    output btb_addr, btb_init, btb_we,
    output bht_addr, bht_init, bht_we,
    output reg_addr, reg_init, reg_we,
    output rst_switch, start_switch, busy, err
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready,
    input  btb_addr, btb_init, btb_we,
    input  bht_addr, bht_init, bht_we,
    input  reg_addr, reg_init, reg_we,
    input  rst_switch, start_switch, busy, err
  );
endinterface

// File: rtl/init_strobe_hold.sv
// Holds one of N write strobes high for exactly HOLD_CYCLES cycles after start.
module init_strobe_hold #(
  parameter int HOLD_CYCLES = 2,
  parameter int N           = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] sel,
  output logic [N-1:0] we,
  output logic         last
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      we  <= '0;
      cnt <= '0;
    end else if (start) begin
      we  <= sel;
      cnt <= CW'(HOLD_CYCLES - 1);
    end else if (we != '0) begin
      if (cnt == '0) we <= '0;
      else           cnt <= cnt - 1'b1;
    end
  end

  // High during the final strobe cycle so the FSM leaves COMMIT as it falls.
  assign last = (we != '0) && (cnt == '0);

endmodule

// File: rtl/cpu_init_loader.sv
// Parses a byte stream into BTB/BHT/REG init writes and CPU start/stop commands.
// Defining CHECKSUM_EN makes every table record carry a trailing XOR byte.
module cpu_init_loader
  import cpu_init_pkg::*;
#(
  parameter int BTB_W       = 40,
  parameter int BTB_AW      = 8,
  parameter int BHT_W       = 2,
  parameter int BHT_AW      = 8,
  parameter int REG_W       = 32,
  parameter int REG_AW      = 5,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  cpu_init_loader_if.master bus
);

  localparam int SH_A = (BTB_W > REG_W) ? BTB_W : REG_W;
  localparam int SH_W = (SH_A > BHT_W) ? SH_A : BHT_W;

  state_t          state;
  logic [1:0]      rec_type;
  logic [7:0]      addr_byte;
  logic [SH_W-1:0] shift;
  logic [SH_W-1:0] shift_next;
  logic [SH_W-1:0] commit_data;
  logic [2:0]      count;
  logic            accept;
  logic            rec_end;
  logic            sum_ok;
  logic            commit_go;
  logic            hold_start;
  logic [2:0]      hold_sel;
  logic [2:0]      hold_we;
  logic            hold_last;
`ifdef CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign bus.s_ready = (state != ST_COMMIT);
  assign accept      = bus.s_valid && bus.s_ready;
  assign shift_next  = {shift[SH_W-9:0], bus.s_data};

  always_comb begin
    commit_data = shift_next;
    sum_ok      = 1'b1;
`ifdef CHECKSUM_EN
    commit_data = shift;
    rec_end     = accept && (state == ST_CHECK);
    sum_ok      = (bus.s_data == csum);
`else
    rec_end     = accept && (state == ST_DATA) && (count == 3'd1);
`endif
    commit_go   = rec_end && sum_ok && !bus.start_switch;
  end

  // Record parser; records ending while the CPU runs, or with a bad checksum, are dropped with err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      rec_type         <= REC_BTB;
      addr_byte        <= '0;
      shift            <= '0;
      count            <= '0;
      bus.rst_switch   <= 1'b1;
      bus.start_switch <= 1'b0;
      bus.busy         <= 1'b0;
      bus.err          <= 1'b0;
`ifdef CHECKSUM_EN
      csum             <= '0;
`endif
    end else begin
      bus.err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rec_type <= bus.s_data[7:6];
            if (bus.s_data[7:6] == REC_CMD) begin
              if (bus.s_data[5:0] == CMD_START) begin
                bus.rst_switch   <= 1'b0;
                bus.start_switch <= 1'b1;
              end else if (bus.s_data[5:0] == CMD_STOP) begin
                bus.rst_switch   <= 1'b1;
                bus.start_switch <= 1'b0;
              end else begin
                bus.err <= 1'b1;
              end
            end else begin
              state    <= ST_ADDR;
              bus.busy <= 1'b1;
              count    <= payload_len(bus.s_data[7:6]);
              shift    <= '0;
`ifdef CHECKSUM_EN
              csum     <= bus.s_data;
`endif
            end
          end
        end
        ST_ADDR: begin
          if (accept) begin
            addr_byte <= bus.s_data;
            state     <= ST_DATA;
`ifdef CHECKSUM_EN
            csum      <= csum ^ bus.s_data;
`endif
          end
        end
        ST_DATA: begin
          if (accept) begin
            shift <= shift_next;
            count <= count - 3'd1;
`ifdef CHECKSUM_EN
            csum  <= csum ^ bus.s_data;
            if (count == 3'd1) state <= ST_CHECK;
`endif
          end
        end
`ifdef CHECKSUM_EN
        ST_CHECK: ;
`endif
        ST_COMMIT: begin
          if (hold_last) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (rec_end) begin
        if (commit_go) begin
          state <= ST_COMMIT;
        end else begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
          bus.err  <= 1'b1;
        end
      end
    end
  end

  // Addr/data are loaded one cycle ahead of the strobe and keep their value afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.btb_addr <= '0;
      bus.btb_init <= '0;
      bus.bht_addr <= '0;
      bus.bht_init <= '0;
      bus.reg_addr <= '0;
      bus.reg_init <= '0;
      hold_start   <= 1'b0;
      hold_sel     <= '0;
    end else begin
      hold_start <= commit_go;
      if (commit_go) begin
        case (rec_type)
          REC_BTB: begin
            bus.btb_addr <= addr_byte[BTB_AW-1:0];
            bus.btb_init <= commit_data[BTB_W-1:0];
            hold_sel     <= 3'b001;
          end
          REC_BHT: begin
            bus.bht_addr <= addr_byte[BHT_AW-1:0];
            bus.bht_init <= commit_data[BHT_W-1:0];
            hold_sel     <= 3'b010;
          end
          default: begin
            bus.reg_addr <= addr_byte[REG_AW-1:0];
            bus.reg_init <= commit_data[REG_W-1:0];
            hold_sel     <= 3'b100;
          end
        endcase
      end
    end
  end

  init_strobe_hold #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .N           (3)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .start (hold_start),
    .sel   (hold_sel),
    .we    (hold_we),
    .last  (hold_last)
  );

  assign bus.btb_we = hold_we[0];
  assign bus.bht_we = hold_we[1];
  assign bus.reg_we = hold_we[2];

endmodule

// File: tb/tb_cpu_init_loader.sv
// Self-checking bench for cpu_init_loader: directed vector table, reset/checksum
// sequences, then a random record stream checked against a record-level model.
module tb_cpu_init_loader;

  localparam int BTB_W       = 40;
  localparam int BTB_AW      = 8;
  localparam int BHT_W       = 2;
  localparam int BHT_AW      = 8;
  localparam int REG_W       = 32;
  localparam int REG_AW      = 5;
  localparam int HOLD_CYCLES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_init_loader_if #(
    .BTB_W(BTB_W), .BTB_AW(BTB_AW), .BHT_W(BHT_W),
    .BHT_AW(BHT_AW), .REG_W(REG_W), .REG_AW(REG_AW)
  ) bus ();

  cpu_init_loader #(
    .BTB_W(BTB_W), .BTB_AW(BTB_AW), .BHT_W(BHT_W), .BHT_AW(BHT_AW),
    .REG_W(REG_W), .REG_AW(REG_AW), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [39:0] data;
    int          len;
    bit          stable;
  } obs_t;

  typedef struct {
    logic [63:0] bytes;
    int          n;
    int          n_commit;
    int          kind;
    logic [7:0]  addr;
    logic [39:0] data;
    int          n_err;
    bit          started;
  } vec_t;

  obs_t       obs_q[$];
  obs_t       exp_q[$];
  logic [7:0] stream_q[$];
  vec_t       vecs[12];
  obs_t       cur[3];
  logic [2:0] prev_we = 3'b000;
  int         tests = 0;
  int         fails = 0;
  int         err_seen = 0;
  int         overlap_cnt = 0;
  bit         model_started;
  int         exp_err;

  wire [2:0] we_now = {bus.reg_we, bus.bht_we, bus.btb_we};

  function automatic obs_t snapshot(input int k);
    obs_t o;
    o.kind   = k;
    o.len    = 0;
    o.stable = 1'b1;
    case (k)
      0:       begin o.addr = bus.btb_addr;         o.data = bus.btb_init;         end
      1:       begin o.addr = bus.bht_addr;         o.data = {38'd0, bus.bht_init}; end
      default: begin o.addr = {3'd0, bus.reg_addr}; o.data = {8'd0, bus.reg_init};  end
    endcase
    return o;
  endfunction

  // Records each strobe window (addr/data at its start, length, stability) when it closes.
  always @(negedge clk) begin
    if (rst) begin
      prev_we = 3'b000;
    end else begin
      if ($countones(we_now) > 1) overlap_cnt++;
      if (bus.err) err_seen++;
      for (int k = 0; k < 3; k++) begin
        obs_t s;
        s = snapshot(k);
        if (we_now[k] && !prev_we[k]) begin
          cur[k]     = s;
          cur[k].len = 1;
        end else if (we_now[k]) begin
          cur[k].len++;
          if (s.addr !== cur[k].addr || s.data !== cur[k].data) cur[k].stable = 1'b0;
        end else if (prev_we[k]) begin
          obs_q.push_back(cur[k]);
        end
      end
      prev_we = we_now;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkObs(input string name, input obs_t got, input obs_t exp);
    checkOutput({name, "_kind"},   64'(got.kind), 64'(exp.kind));
    checkOutput({name, "_addr"},   64'(got.addr), 64'(exp.addr));
    checkOutput({name, "_data"},   64'(got.data), 64'(exp.data));
    checkOutput({name, "_len"},    64'(got.len),  64'(HOLD_CYCLES));
    checkOutput({name, "_stable"}, 64'(got.stable), 64'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int g;
    g = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    while (!bus.s_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    checkOutput("s_ready_wait", 64'(bus.s_ready), 64'd1);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

`ifdef CHECKSUM_EN
  task automatic applyRecordSum(input logic [63:0] bytes, input int n, input logic [7:0] flip);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      b = bytes[63-8*k -: 8];
      x = x ^ b;
      applyStimulus(b, 0);
    end
    if (bytes[63:62] != 2'b11) applyStimulus(x ^ flip, 0);
  endtask
`endif

  task automatic applyRecord(input logic [63:0] bytes, input int n);
`ifdef CHECKSUM_EN
    applyRecordSum(bytes, n, 8'h00);
`else
    for (int k = 0; k < n; k++) applyStimulus(bytes[63-8*k -: 8], 0);
`endif
  endtask

  task automatic waitIdle(input string name);
    int g;
    g = 0;
    @(negedge clk);
    while ((bus.busy || we_now != 3'b000) && g < 200) begin
      @(negedge clk);
      g++;
    end
    checkOutput({name, "_idle"}, {60'd0, bus.busy, we_now}, 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Record-level model: walks the byte stream record by record.
  task automatic runModel();
    int i;
    i = 0;
    while (i < stream_q.size()) begin
      logic [7:0]  h;
      logic [7:0]  x;
      logic [39:0] d;
      int          len;
      int          total;
      bit          ok;
      obs_t        o;
      h = stream_q[i];
      if (h[7:6] == 2'b11) begin
        if (h[5:0] == 6'h00)      model_started = 1'b1;
        else if (h[5:0] == 6'h01) model_started = 1'b0;
        else                      exp_err++;
        i++;
      end else begin
        len = (h[7:6] == 2'b00) ? 5 : (h[7:6] == 2'b01) ? 1 : 4;
        d   = '0;
        for (int k = 0; k < len; k++) d = {d[31:0], stream_q[i+2+k]};
        total = 2 + len;
        ok    = 1'b1;
        x     = 8'h00;
`ifdef CHECKSUM_EN
        for (int k = 0; k < total; k++) x = x ^ stream_q[i+k];
        ok    = (x == stream_q[i+total]);
        total = total + 1;
`endif
        if (!ok || model_started) begin
          exp_err++;
        end else begin
          o.kind   = int'(h[7:6]);
          o.addr   = (h[7:6] == 2'b10) ? (stream_q[i+1] & 8'h1F) : stream_q[i+1];
          o.data   = (h[7:6] == 2'b01) ? (d & 40'h3) : d;
          o.len    = HOLD_CYCLES;
          o.stable = 1'b1;
          exp_q.push_back(o);
        end
        i += total;
      end
    end
  endtask

  initial begin
    int   base_o;
    int   base_e;
    obs_t e;
    obs_t s;

    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    resetDut();
    @(negedge clk);
    checkOutput("reset_rst_switch",   64'(bus.rst_switch),   64'd1);
    checkOutput("reset_start_switch", 64'(bus.start_switch), 64'd0);
    checkOutput("reset_s_ready",      64'(bus.s_ready),      64'd1);
    checkOutput("reset_strobes",      64'(we_now),           64'd0);
    checkOutput("reset_busy",         64'(bus.busy),         64'd0);
    checkOutput("reset_err",          64'(bus.err),          64'd0);
    checkOutput("reset_btb",          {16'd0, bus.btb_addr, bus.btb_init}, 64'd0);
    checkOutput("reset_bht",          64'({bus.bht_addr, bus.bht_init}),  64'd0);
    checkOutput("reset_reg",          64'({bus.reg_addr, bus.reg_init}),  64'd0);

    vecs[0]  = '{64'h0010_1234_5678_9A00, 7, 1, 0, 8'h10, 40'h12_3456_789A, 0, 1'b0};
    vecs[1]  = '{64'h8023_DEAD_BEEF_0000, 6, 1, 2, 8'h03, 40'hDE_ADBE_EF,   0, 1'b0};
    vecs[2]  = '{64'h4007_0300_0000_0000, 3, 1, 1, 8'h07, 40'h3,            0, 1'b0};
    vecs[3]  = '{64'hC000_0000_0000_0000, 1, 0, 0, 8'h00, 40'h0,            0, 1'b1};
    vecs[4]  = '{64'h4001_0200_0000_0000, 3, 0, 0, 8'h00, 40'h0,            1, 1'b1};
    vecs[5]  = '{64'hC000_0000_0000_0000, 1, 0, 0, 8'h00, 40'h0,            0, 1'b1};
    vecs[6]  = '{64'hC100_0000_0000_0000, 1, 0, 0, 8'h00, 40'h0,            0, 1'b0};
    vecs[7]  = '{64'hC100_0000_0000_0000, 1, 0, 0, 8'h00, 40'h0,            0, 1'b0};
    vecs[8]  = '{64'hC500_0000_0000_0000, 1, 0, 0, 8'h00, 40'h0,            1, 1'b0};
    vecs[9]  = '{64'h80FF_0000_0001_0000, 6, 1, 2, 8'h1F, 40'h1,            0, 1'b0};
    vecs[10] = '{64'h3FFF_FFFF_FFFF_FF00, 7, 1, 0, 8'hFF, 40'hFF_FFFF_FFFF, 0, 1'b0};
    vecs[11] = '{64'h40FF_FE00_0000_0000, 3, 1, 1, 8'hFF, 40'h2,            0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      base_o = obs_q.size();
      base_e = err_seen;
      applyRecord(vecs[i].bytes, vecs[i].n);
      waitIdle($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d_commits", i), 64'(obs_q.size() - base_o), 64'(vecs[i].n_commit));
      if (vecs[i].n_commit == 1 && obs_q.size() == base_o + 1) begin
        e = '{vecs[i].kind, vecs[i].addr, vecs[i].data, HOLD_CYCLES, 1'b1};
        checkObs($sformatf("vec%0d", i), obs_q[base_o], e);
        s = snapshot(vecs[i].kind);
        checkOutput($sformatf("vec%0d_held_addr", i), 64'(s.addr), 64'(vecs[i].addr));
        checkOutput($sformatf("vec%0d_held_data", i), 64'(s.data), 64'(vecs[i].data));
      end
      checkOutput($sformatf("vec%0d_err", i), 64'(err_seen - base_e), 64'(vecs[i].n_err));
      checkOutput($sformatf("vec%0d_start_switch", i), 64'(bus.start_switch), 64'(vecs[i].started));
      checkOutput($sformatf("vec%0d_rst_switch", i), 64'(bus.rst_switch), 64'(!vecs[i].started));
    end

    // Reset in the middle of a record while started.
    base_o = obs_q.size();
    applyRecord(64'hC000_0000_0000_0000, 1);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h10, 0);
    applyStimulus(8'h12, 0);
    applyStimulus(8'h34, 0);
    checkOutput("midrec_busy", 64'(bus.busy), 64'd1);
    resetDut();
    @(negedge clk);
    checkOutput("midrst_busy",         64'(bus.busy),         64'd0);
    checkOutput("midrst_rst_switch",   64'(bus.rst_switch),   64'd1);
    checkOutput("midrst_start_switch", 64'(bus.start_switch), 64'd0);
    checkOutput("midrst_btb",          {16'd0, bus.btb_addr, bus.btb_init}, 64'd0);
    checkOutput("midrst_reg",          64'({bus.reg_addr, bus.reg_init}),  64'd0);
    checkOutput("midrst_bht",          64'({bus.bht_addr, bus.bht_init}),  64'd0);
    applyRecord(64'h4005_0100_0000_0000, 3);
    waitIdle("post_reset");
    checkOutput("post_reset_commits", 64'(obs_q.size() - base_o), 64'd1);
    if (obs_q.size() == base_o + 1) begin
      e = '{1, 8'h05, 40'h1, HOLD_CYCLES, 1'b1};
      checkObs("post_reset", obs_q[base_o], e);
    end

`ifdef CHECKSUM_EN
    base_o = obs_q.size();
    base_e = err_seen;
    applyRecordSum(64'h4002_0100_0000_0000, 3, 8'h00);
    waitIdle("csum_good");
    checkOutput("csum_good_commits", 64'(obs_q.size() - base_o), 64'd1);
    if (obs_q.size() == base_o + 1) begin
      e = '{1, 8'h02, 40'h1, HOLD_CYCLES, 1'b1};
      checkObs("csum_good", obs_q[base_o], e);
    end
    applyRecordSum(64'h4002_0100_0000_0000, 3, 8'h07);
    waitIdle("csum_bad");
    checkOutput("csum_bad_commits", 64'(obs_q.size() - base_o), 64'd1);
    checkOutput("csum_bad_err",     64'(err_seen - base_e),     64'd1);
`endif

    // Random record stream against the record-level model.
    model_started = 1'b0;
    exp_err       = 0;
    exp_q.delete();
    stream_q.delete();
    for (int r = 0; r < 60; r++) begin
      int         sel;
      int         len;
      logic [7:0] hdr;
      logic [7:0] b;
      logic [7:0] x;
      sel = $urandom_range(0, 9);
      if (sel >= 8) begin
        hdr = (sel == 8) ? {2'b11, 6'($urandom_range(0, 1))} : {2'b11, 6'($urandom_range(0, 63))};
        stream_q.push_back(hdr);
      end else begin
        hdr = {(sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : 2'b10, 6'($urandom_range(0, 63))};
        len = (sel < 3) ? 5 : (sel < 6) ? 1 : 4;
        stream_q.push_back(hdr);
        x = hdr;
        for (int k = 0; k < len + 1; k++) begin
          b = 8'($urandom_range(0, 255));
          x = x ^ b;
          stream_q.push_back(b);
        end
`ifdef CHECKSUM_EN
        stream_q.push_back(x ^ (($urandom_range(0, 7) == 0) ? 8'h07 : 8'h00));
`endif
      end
    end
    runModel();
    base_o = obs_q.size();
    base_e = err_seen;
    for (int k = 0; k < stream_q.size(); k++)
      applyStimulus(stream_q[k], ($urandom_range(0, 3) == 0) ? 1 : 0);
    waitIdle("rand");
    checkOutput("rand_commits", 64'(obs_q.size() - base_o), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size(); j++)
      if (base_o + j < obs_q.size()) checkObs($sformatf("rand%0d", j), obs_q[base_o + j], exp_q[j]);
    checkOutput("rand_err",          64'(err_seen - base_e), 64'(exp_err));
    checkOutput("rand_start_switch", 64'(bus.start_switch),  64'(model_started));
    checkOutput("rand_rst_switch",   64'(bus.rst_switch),    64'(!model_started));
    checkOutput("strobe_overlap",    64'(overlap_cnt),       64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_init_loader.md
Name: cpu_init_loader

Overview:
Host-side writer for the CPU's table-initialization interface. It parses a byte stream, assembles BTB, BHT and register-file init records, and drives the matching addr/init/strobe outputs. It sequences the CPU reset/start switches and sits between a byte source (e.g. UART RX) and the CPU top-level init ports.

Parameters:
BTB_W, 40, BTB entry width
BTB_AW, 8, BTB address width
BHT_W, 2, BHT counter width
BHT_AW, 8, BHT address width
REG_W, 32, register init data width
REG_AW, 5, register address width
HOLD_CYCLES, 2, cycles a write strobe plus its addr/data stay stable (covers the half-rate clk_50 sampling)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
s_valid  in  1  input byte valid
s_data  in  8  input byte
s_ready  out  1  loader accepts a byte this cycle
btb_addr  out  BTB_AW  BTB init address
btb_init  out  BTB_W  BTB init data
btb_we  out  1  BTB write strobe
bht_addr  out  BHT_AW  BHT init address
bht_init  out  BHT_W  BHT init data
bht_we  out  1  BHT write strobe
reg_addr  out  REG_AW  register init address
reg_init  out  REG_W  register init data
reg_we  out  1  register write strobe
rst_switch  out  1  holds CPU in init mode
start_switch  out  1  releases CPU to run
busy  out  1  record in progress
err  out  1  one-cycle pulse on a malformed or dropped record

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all addr/init outputs are 0; all strobes are 0; rst_switch=1, start_switch=0, busy=0, err=0, s_ready=1.
- Handshake: a byte transfers when s_valid&&s_ready. s_ready=0 only in COMMIT.
- Header byte layout: [7:6] selects type: 00 BTB, 01 BHT, 10 REG, 11 CMD. [5:0] is the command code for CMD and is ignored otherwise.
- Record format after the header:
  - Address byte: REG uses bits [4:0]; upper bits are ignored.
  - Data bytes, MSB first: BTB 5, BHT 1 (bits [1:0] used), REG 4.
- CMD codes carry no payload: 0x00 START, 0x01 STOP. Any other code pulses err and is discarded.
- State machine: IDLE -> ADDR -> DATA -> COMMIT -> IDLE. CMD headers are executed from IDLE directly.
  - IDLE: waits for a header.
  - ADDR: takes one byte.
  - DATA: a byte counter counts down the payload length.
  - COMMIT: drives addr/data and asserts the selected *_we for exactly HOLD_CYCLES cycles, then drops it. Addr/data hold their values after the strobe falls.
- busy=1 from header acceptance until COMMIT exits.
- START: rst_switch goes to 0 and start_switch to 1 on the next cycle. They stay there until STOP or reset.
- STOP: rst_switch=1, start_switch=0.
- Records arriving while start_switch=1 are parsed but not committed: no strobe, err pulses at record end.
- START arriving while started is a no-op. STOP arriving while stopped is a no-op.
- Only one strobe is ever active at a time.
- Reset during any state returns to IDLE with reset values. A partial record is discarded.
- Data shift register: a left shift of 8 per byte. The width equals the record width; no sign or zero extension beyond that.

Optional Feature:
- Macro: CHECKSUM_EN.
- Defined:
  - Every BTB/BHT/REG record carries one extra trailing byte, the XOR of all preceding record bytes including the header.
  - The FSM gains a CHECK state after DATA.
  - On a mismatch: no COMMIT, err pulses for 1 cycle, return to IDLE.
  - CMD headers remain checksum-free.
- Undefined: no trailing byte, no CHECK state, and no checksum logic is synthesized.

Decomposition:
- Shared package cpu_init_pkg holds:
  - Record type constants REC_BTB/REC_BHT/REC_REG/REC_CMD.
  - CMD_START=0x00 and CMD_STOP=0x01.
  - Payload-length constants (5, 1, 4).
  - The FSM state enumeration.
- One natural sub-module: init_strobe_hold, a HOLD_CYCLES counter that generates the strobe window.

Test Plan:
- Reset, then idle -> rst_switch=1, start_switch=0, s_ready=1, all strobes 0.
- Bytes 00,10,12,34,56,78,9A -> btb_addr=0x10, btb_init=0x123456789A, btb_we high 2 cycles, busy low afterwards.
- Bytes 80,23,DE,AD,BE,EF then 40,07,03 -> reg_addr=3 (0x23&0x1F), reg_init=0xDEADBEEF with reg_we; then bht_addr=7, bht_init=2'b11 with bht_we; strobes never overlap.
- Byte C0 -> start_switch=1, rst_switch=0. Then 40,01,02 -> no bht_we, err pulse. Then C1 -> rst_switch=1.
- Reset asserted after header 00 and two data bytes -> IDLE; next record 40,05,01 commits bht_addr=5, bht_init=1.
- With CHECKSUM_EN: 40,02,01 plus checksum 43 commits; the same record with checksum 44 gives err and no bht_we.
